float_sub: RTL and testbench
============================

FLOAT_SUB -- requirements
Module: float_sub

Interface
REQ-001 SHALL have no parameters; the operand format is fixed at 8 bits: [7] sign, [6:4] exponent e, [3:0] mantissa m.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand pair a/b is presented.
REQ-006 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-007 a  input  8  minuend; sign bit [7] is ignored.
REQ-008 b  input  8  subtrahend; sign bit [7] is ignored.
REQ-009 out_valid  output  1  result is valid; high only in DONE.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out  output  8  result in {sign, e, m} format.
REQ-012 uflow  output  1  the result was flushed to zero because of underflow.

Function
REQ-013 SHALL decode each operand as significand s = {h, m} (5 bits), with h = 0 when e == 0 and h = 1 otherwise.
REQ-014 SHALL compute a - b over the operand magnitudes.
REQ-015 SHALL use a four-state FSM: IDLE, ALIGN, NORM, DONE.
REQ-016 IDLE: when in_valid is high, SHALL register a and b and go to ALIGN; otherwise SHALL remain in IDLE.
REQ-017 ALIGN (one cycle): SHALL select the larger operand L (higher e; if exponents are equal, the higher s; if equal, a).
REQ-018 ALIGN: SHALL compute d = eL - eS, right-shift sS by d with shifted-out bits truncated, set diff = sL - (sS >> d) (5 bits, never negative), set sign = (L is b), set e = eL, then go to NORM.
REQ-019 NORM, evaluated in priority order each cycle:
- diff == 0 -> result 0x00 (sign forced to 0), go to DONE.
- e == 0 -> result {sign, 000, diff[3:0]}, go to DONE.
- diff[4] == 1 -> result {sign, e, diff[3:0]}, go to DONE.
- e == 1 -> result 0x00, uflow = 1, go to DONE.
- otherwise -> diff <<= 1, e -= 1, stay in NORM.
REQ-020 Each NORM shift SHALL take one cycle, with at most 4 shifts per operation.
REQ-021 DONE: SHALL drive out_valid = 1 and hold out and uflow stable; when out_ready is high, SHALL go to IDLE.
REQ-022 out and uflow SHALL hold their values after the DONE handshake until the next result is produced.
REQ-023 Latency: with k NORM shifts, out_valid SHALL rise 2 + k clock edges after the accepting edge (minimum 2, maximum 6).
REQ-024 in_valid SHALL be ignored outside IDLE; operands presented while busy are not captured.
REQ-025 Back-to-back operation: operands SHALL be accepted no earlier than the cycle after the DONE handshake, because in_ready is low in DONE.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE, out = 0x00, uflow = 0 and clear internal registers.
REQ-027 Reset values: out_valid = 0, in_ready = 1.
REQ-028 Reset during ALIGN, NORM or DONE SHALL abort the operation without producing a result, with out_valid = 0 from the next cycle.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-030 Macro FLOAT_SUB_FASTNORM_EN defined: NORM SHALL complete in exactly one cycle, using a leading-one priority encode that applies the same shift limit and rules as REQ-019.
REQ-031 With FLOAT_SUB_FASTNORM_EN defined, out_valid SHALL rise exactly 3 edges after acceptance.
REQ-032 Macro FLOAT_SUB_FASTNORM_EN undefined: iterative one-bit-per-cycle normalization per REQ-020 and REQ-023.
REQ-033 Results (out, uflow) SHALL be bit-identical with and without FLOAT_SUB_FASTNORM_EN.

Verification
REQ-034 a=0x35, b=0x30 -> out=0x14, uflow=0; out_valid 4 edges after accept (3 with FASTNORM).
REQ-035 a=0x30, b=0x35 -> out=0x94 (sign set); a=b=0x4A -> out=0x00, uflow=0.
REQ-036 Underflow: a=0x11, b=0x10 -> out=0x00, uflow=1; alignment truncation: a=0x50, b=0x1F -> out=0x4E.
REQ-037 Exponent-0 operands: a=0x0C, b=0x05 -> out=0x07 via the e==0 path, 2 edges latency.
REQ-038 Backpressure: out_ready held low for 5 cycles in DONE -> out_valid=1 and out stable throughout, in_ready=0, in_valid pulses ignored; after out_ready=1, in_ready=1 the next cycle.
REQ-039 rst pulsed during NORM -> next cycle state is IDLE, out_valid=0, out=0x00, in_ready=1; the following operation computes correctly.

Source files
------------

// File: rtl/float_sub_if.sv
// float_sub_if: operand/result handshake bundle for the float_sub mini-float subtractor.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Ports: master = operand producer / result consumer, slave = the subtractor.
interface float_sub_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       uflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, uflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, uflow
    );
endinterface

// File: rtl/float_sub.sv
// float_sub: |a| - |b| on 8-bit {sign, e[2:0], m[3:0]} mini-floats, result sign set when |b| is larger.
// Latency: 2 + k edges from accept (k = normalization shifts, 0..4); exactly 3 with FLOAT_SUB_FASTNORM_EN.
// Backpressure: result held in DONE until out_ready; in_ready high only in IDLE, operands ignored when busy.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (float_sub_if.slave).
// Option: define FLOAT_SUB_FASTNORM_EN to normalize with a single leading-one shift instead of 1 bit/cycle.
module float_sub (
    input  logic        clk,
    input  logic        rst,
    float_sub_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ALIGN, NORM, DONE} state_t;

    state_t     state, state_nxt;
    logic [6:0] a_q, a_nxt;
    logic [6:0] b_q, b_nxt;
    logic [4:0] diff_q, diff_nxt;
    logic [2:0] exp_q, exp_nxt;
    logic       sign_q, sign_nxt;
    logic [7:0] out_q, out_nxt;
    logic       uflow_q, uflow_nxt;

    // Alignment datapath, only consumed in ALIGN.
    logic [2:0] exp_a, exp_b, exp_l, exp_s, shift_d;
    logic [4:0] sig_a, sig_b, sig_l, sig_s, align_diff;
    logic       a_is_large;

    always_comb begin
        exp_a      = a_q[6:4];
        exp_b      = b_q[6:4];
        // Hidden bit is implicit for every non-zero exponent.
        sig_a      = {(exp_a != 3'd0), a_q[3:0]};
        sig_b      = {(exp_b != 3'd0), b_q[3:0]};
        a_is_large = (exp_a > exp_b) || ((exp_a == exp_b) && (sig_a >= sig_b));
        exp_l      = a_is_large ? exp_a : exp_b;
        exp_s      = a_is_large ? exp_b : exp_a;
        sig_l      = a_is_large ? sig_a : sig_b;
        sig_s      = a_is_large ? sig_b : sig_a;
        shift_d    = exp_l - exp_s;
        // Larger operand is chosen first, so this never wraps.
        align_diff = sig_l - (sig_s >> shift_d);
    end

`ifdef FLOAT_SUB_FASTNORM_EN
    // One-shot normalization: shift by min(leading zeros, e - 1), which is exactly where the
    // bit-serial loop would stop (leading one reaches bit 4, or e reaches 1 for underflow).
    logic       norm_done_q, norm_done_nxt;
    logic [2:0] lead_zeros, shamt;

    always_comb begin
        lead_zeros = 3'd4;
        if (diff_q[4])      lead_zeros = 3'd0;
        else if (diff_q[3]) lead_zeros = 3'd1;
        else if (diff_q[2]) lead_zeros = 3'd2;
        else if (diff_q[1]) lead_zeros = 3'd3;
        shamt = 3'd0;
        if ((diff_q != 5'd0) && (exp_q != 3'd0))
            shamt = (lead_zeros < (exp_q - 3'd1)) ? lead_zeros : (exp_q - 3'd1);
    end
`endif

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        diff_nxt  = diff_q;
        exp_nxt   = exp_q;
        sign_nxt  = sign_q;
        out_nxt   = out_q;
        uflow_nxt = uflow_q;
`ifdef FLOAT_SUB_FASTNORM_EN
        norm_done_nxt = norm_done_q;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    a_nxt     = bus.a[6:0];
                    b_nxt     = bus.b[6:0];
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                diff_nxt  = align_diff;
                exp_nxt   = exp_l;
                sign_nxt  = !a_is_large;
                state_nxt = NORM;
`ifdef FLOAT_SUB_FASTNORM_EN
                norm_done_nxt = 1'b0;
`endif
            end
            NORM: begin
`ifdef FLOAT_SUB_FASTNORM_EN
                if (!norm_done_q) begin
                    diff_nxt      = diff_q << shamt;
                    exp_nxt       = exp_q - shamt;
                    norm_done_nxt = 1'b1;
                end else
`endif
                if (diff_q == 5'd0) begin
                    out_nxt   = 8'h00;
                    uflow_nxt = 1'b0;
                    state_nxt = DONE;
                end else if (exp_q == 3'd0) begin
                    out_nxt   = {sign_q, 3'b000, diff_q[3:0]};
                    uflow_nxt = 1'b0;
                    state_nxt = DONE;
                end else if (diff_q[4]) begin
                    out_nxt   = {sign_q, exp_q, diff_q[3:0]};
                    uflow_nxt = 1'b0;
                    state_nxt = DONE;
                end else if (exp_q == 3'd1) begin
                    // No room to shift further: flush to zero.
                    out_nxt   = 8'h00;
                    uflow_nxt = 1'b1;
                    state_nxt = DONE;
                end else begin
                    diff_nxt = diff_q << 1;
                    exp_nxt  = exp_q - 3'd1;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= 7'd0;
            b_q     <= 7'd0;
            diff_q  <= 5'd0;
            exp_q   <= 3'd0;
            sign_q  <= 1'b0;
            out_q   <= 8'h00;
            uflow_q <= 1'b0;
`ifdef FLOAT_SUB_FASTNORM_EN
            norm_done_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            diff_q  <= diff_nxt;
            exp_q   <= exp_nxt;
            sign_q  <= sign_nxt;
            out_q   <= out_nxt;
            uflow_q <= uflow_nxt;
`ifdef FLOAT_SUB_FASTNORM_EN
            norm_done_q <= norm_done_nxt;
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign bus.uflow     = uflow_q;

endmodule

// File: tb/tb_float_sub.sv
// tb_float_sub: scoreboard bench for float_sub; driver pushes expected results, monitor pops and compares.
// Latency: checks result latency per operation against the reference model.
// Backpressure: drives random and directed out_ready stalls and junk in_valid while busy.
module tb_float_sub;

`ifdef FLOAT_SUB_FASTNORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_sub_if bus();

    float_sub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] out;
        logic       uflow;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_seen = 1'b0;
    logic seen = 1'b0;
    logic [7:0] last_out = 8'h00;
    logic last_uflow = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int lat_of(input int k);
        return FAST ? 3 : 2 + k;
    endfunction

    // Reference: plain integer arithmetic on magnitudes, then normalize by counting leading zeros.
    function automatic void ref_sub(input logic [7:0] x, input logic [7:0] y,
                                    output logic [7:0] o, output logic u, output int lat);
        int ex, ey, sx, sy, el, sl, ss, d, df, lz, k, res;
        bit sg;
        ex = int'(x[6:4]);
        ey = int'(y[6:4]);
        sx = (ex != 0 ? 16 : 0) + int'(x[3:0]);
        sy = (ey != 0 ? 16 : 0) + int'(y[3:0]);
        if (ex > ey || (ex == ey && sx >= sy)) begin
            el = ex; sl = sx; ss = sy; d = ex - ey; sg = 1'b0;
        end else begin
            el = ey; sl = sy; ss = sx; d = ey - ex; sg = 1'b1;
        end
        df  = sl - ss / (2 ** d);
        res = 0;
        u   = 1'b0;
        k   = 0;
        if (df == 0) begin
            res = 0;
        end else if (el == 0) begin
            res = (sg ? 128 : 0) + df;
        end else begin
            lz = 0;
            while (df * (2 ** lz) < 16) lz++;
            if (lz <= el - 1) begin
                k   = lz;
                res = (sg ? 128 : 0) + (el - lz) * 16 + (df * (2 ** lz) - 16);
            end else begin
                k = el - 1;
                u = 1'b1;
            end
        end
        o   = res[7:0];
        lat = lat_of(k);
    endfunction

    // Monitor: pops on the first cycle of each out_valid, otherwise expects out/uflow to hold.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_seen) begin
                sb_q.delete();
                last_out   = 8'h00;
                last_uflow = 1'b0;
                seen       = 1'b0;
            end
            if (bus.out_valid === 1'b1 && !seen) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual out=%02h required no result", bus.out);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("result_out", 32'(bus.out), 32'(mon_e.out));
                    chk("result_uflow", 32'(bus.uflow), 32'(mon_e.uflow));
                    chk("result_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    last_out   = mon_e.out;
                    last_uflow = mon_e.uflow;
                end
                seen = 1'b1;
            end else begin
                chk("held_out", 32'(bus.out), 32'(last_out));
                chk("held_uflow", 32'(bus.uflow), 32'(last_uflow));
                if (bus.out_valid !== 1'b1) seen = 1'b0;
            end
        end
    end

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [7:0] eo, input logic eu, input int el, input int hold);
        int guard;
        exp_t e;
        @(negedge clk);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a        = ta;
        bus.b        = tb_v;
        bus.in_valid = 1'b1;
        e.out = eo; e.uflow = eu; e.lat = el; e.acc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        // Junk operands while busy must be ignored.
        while (bus.out_valid !== 1'b1 && guard < 20) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            @(negedge clk);
            guard++;
        end
        if (bus.out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual out_valid=%0b required 1", bus.out_valid);
        end
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = 8'($urandom);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_handshake_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_handshake_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] o;
        logic       u;
        int         k;
    } vec_t;

    vec_t dir[6];

    initial begin
        logic [7:0] ra, rb, ro;
        logic ru;
        int rl, guard;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;

        dir[0] = '{8'h35, 8'h30, 8'h14, 1'b0, 2};
        dir[1] = '{8'h30, 8'h35, 8'h94, 1'b0, 2};
        dir[2] = '{8'h4A, 8'h4A, 8'h00, 1'b0, 0};
        dir[3] = '{8'h11, 8'h10, 8'h00, 1'b1, 0};
        dir[4] = '{8'h50, 8'h1F, 8'h4E, 1'b0, 1};
        dir[5] = '{8'h0C, 8'h05, 8'h07, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out", 32'(bus.out), 32'h00);
        chk("reset_uflow", 32'(bus.uflow), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_op(dir[i].a, dir[i].b, dir[i].o, dir[i].u, lat_of(dir[i].k), i % 2);

        // Long stall in DONE.
        do_op(8'h35, 8'h30, 8'h14, 1'b0, lat_of(2), 5);

        // Reset while in NORM aborts without a result.
        @(negedge clk);
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.a = 8'h35; bus.b = 8'h30; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("norm_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out", 32'(bus.out), 32'h00);
        chk("abort_uflow", 32'(bus.uflow), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        do_op(8'h35, 8'h30, 8'h14, 1'b0, lat_of(2), 0);

        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb[6:4] = ra[6:4];
            if ($urandom_range(0, 5) == 0) begin
                ra[6:4] = 3'($urandom_range(0, 1));
                rb[6:4] = 3'($urandom_range(0, 1));
            end
            ref_sub(ra, rb, ro, ru, rl);
            do_op(ra, rb, ro, ru, rl, $urandom_range(0, 2));
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
